// File: rtl/sys_arr_pkg.sv
// Shared definitions for the systolic-array memory driver.
//   N_DEF   : default array dimension
//   ROW_W   : row-index width for the default dimension
//   state_t : driver sequencing states
package sys_arr_pkg;

  localparam int N_DEF = 4;
  localparam int ROW_W = $clog2(N_DEF);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_RD    = 3'd1,
    W_BEAT  = 3'd2,
    I_RD    = 3'd3,
    I_BEAT  = 3'd4,
    COLLECT = 3'd5
  } state_t;

endpackage

// File: rtl/sysarr_mem_driver.sv
// Memory-side initiator for the systolic array load/drain protocol.
// A start command loads N weight rows, then N input rows paired with N
// partial-sum rows, from the scratchpad into the array. Output rows returned
// by the array are written back to the scratchpad. done pulses once all N
// output rows have been seen and the array reports drained.
//
// Ports:
//   clk, nRST                    clock, asynchronous active-low reset
//   start                        job strobe, honoured only in IDLE
//   w_base/i_base/p_base/o_base  scratchpad row bases, latched on start
//   busy, done                   job status
//   rda_*                        read port A (weights and inputs)
//   rdb_*                        read port B (partials)
//   wr_*                         scratchpad write port (output rows)
//   weight_en/input_en/partial_en, row_in_en/row_ps_en,
//   array_in/array_in_partials   beats issued to the array
//   fifo_has_space               array can take an input/partial beat
//   out_en/row_out/array_output  output rows returned by the array
//   drained                      array has no work in flight
//
// State table:
//   IDLE    | waiting for start
//   W_RD    | read weight row wr_cnt on port A
//   W_BEAT  | issue weight row to the array
//   I_RD    | read input row (A) and partial row (B) ir_cnt
//   I_BEAT  | issue input + partial row once the array has space
//   COLLECT | wait for all N outputs and drained, then done
module sysarr_mem_driver
  import sys_arr_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 start,
  input  logic [AW-1:0]        w_base,
  input  logic [AW-1:0]        i_base,
  input  logic [AW-1:0]        p_base,
  input  logic [AW-1:0]        o_base,
  output logic                 busy,
  output logic                 done,
  output logic                 rda_en,
  output logic [AW-1:0]        rda_addr,
  input  logic [DW*N-1:0]      rda_data,
  output logic                 rdb_en,
  output logic [AW-1:0]        rdb_addr,
  input  logic [DW*N-1:0]      rdb_data,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW*N-1:0]      wr_data,
  output logic                 weight_en,
  output logic                 input_en,
  output logic                 partial_en,
  output logic [$clog2(N)-1:0] row_in_en,
  output logic [$clog2(N)-1:0] row_ps_en,
  output logic [DW*N-1:0]      array_in,
  output logic [DW*N-1:0]      array_in_partials,
  input  logic                 fifo_has_space,
  input  logic                 out_en,
  input  logic [$clog2(N)-1:0] row_out,
  input  logic [DW*N-1:0]      array_output,
  input  logic                 drained
);

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
  localparam logic [RW:0]   FULL_CNT = (RW + 1)'(N);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] w_base_q;
  logic [AW-1:0] i_base_q;
  logic [AW-1:0] p_base_q;
  logic [AW-1:0] o_base_q;
  logic [RW-1:0] wr_cnt;
  logic [RW-1:0] ir_cnt;
  logic [RW:0]   out_cnt;

  logic accept;
  logic beat_i;
  logic capture;
  logic out_full;
  logic job_done;

  assign accept   = (state == IDLE) && start;
  assign beat_i   = (state == I_BEAT) && fifo_has_space;
  assign capture  = (state != IDLE) && out_en;
  assign out_full = (out_cnt == FULL_CNT);
  assign job_done = (state == COLLECT) && out_full && drained;

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Job context and counters
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      w_base_q <= '0;
      i_base_q <= '0;
      p_base_q <= '0;
      o_base_q <= '0;
      wr_cnt   <= '0;
      ir_cnt   <= '0;
      out_cnt  <= '0;
    end else if (accept) begin
      w_base_q <= w_base;
      i_base_q <= i_base;
      p_base_q <= p_base;
      o_base_q <= o_base;
      wr_cnt   <= '0;
      ir_cnt   <= '0;
      out_cnt  <= '0;
    end else begin
      // Row counters wrap back to 0 after the last row, which is harmless:
      // the state machine has already moved past the phase that uses them.
      if (state == W_BEAT) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (beat_i) begin
        ir_cnt <= ir_cnt + 1'b1;
      end
      if (capture && !out_full) begin
        out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = W_RD;
      W_RD:    state_nx = W_BEAT;
      W_BEAT:  state_nx = (wr_cnt == LAST_ROW) ? I_RD : W_RD;
      I_RD:    state_nx = I_BEAT;
      I_BEAT: begin
        if (fifo_has_space) begin
          state_nx = (ir_cnt == LAST_ROW) ? COLLECT : I_RD;
        end
      end
      COLLECT: if (job_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy              = (state != IDLE) && !job_done;
    done              = job_done;
    rda_en            = 1'b0;
    rda_addr          = '0;
    rdb_en            = 1'b0;
    rdb_addr          = '0;
    weight_en         = 1'b0;
    input_en          = 1'b0;
    partial_en        = 1'b0;
    row_in_en         = '0;
    row_ps_en         = '0;
    array_in          = '0;
    array_in_partials = '0;
    wr_en             = 1'b0;
    wr_addr           = '0;
    wr_data           = '0;

    case (state)
      W_RD: begin
        rda_en   = 1'b1;
        rda_addr = w_base_q + AW'(wr_cnt);
      end
      W_BEAT: begin
        weight_en = 1'b1;
        array_in  = rda_data;
      end
      I_RD: begin
        rda_en   = 1'b1;
        rda_addr = i_base_q + AW'(ir_cnt);
        rdb_en   = 1'b1;
        rdb_addr = p_base_q + AW'(ir_cnt);
      end
      I_BEAT: begin
        // A stalled beat does not re-read: read data stays valid until the
        // next read strobe, so the held rows are still on rda/rdb_data.
        if (fifo_has_space) begin
          input_en          = 1'b1;
          partial_en        = 1'b1;
          row_in_en         = ir_cnt;
          row_ps_en         = ir_cnt;
          array_in          = rda_data;
          array_in_partials = rdb_data;
        end
      end
      default: ;
    endcase

    // Output rows use the write port only, so capture never contends with
    // the read-side beats above.
    if (capture) begin
      wr_en   = 1'b1;
      wr_addr = o_base_q + AW'(row_out);
      wr_data = array_output;
    end
  end

endmodule

// File: tb/tb_sysarr_mem_driver.sv
module tb_sysarr_mem_driver;

  logic        clk;
  logic        nRST;
  logic        start;
  logic [15:0] w_base, i_base, p_base, o_base;
  logic        busy, done;
  logic        rda_en, rdb_en, wr_en;
  logic [15:0] rda_addr, rdb_addr, wr_addr;
  logic [63:0] rda_data, rdb_data, wr_data;
  logic        weight_en, input_en, partial_en;
  logic [1:0]  row_in_en, row_ps_en, row_out;
  logic [63:0] array_in, array_in_partials, array_output;
  logic        fifo_has_space, out_en, drained;

  int total = 0;
  int bad   = 0;

  sysarr_mem_driver #(.N(4), .DW(16), .AW(16)) dut (
    .clk(clk), .nRST(nRST), .start(start),
    .w_base(w_base), .i_base(i_base), .p_base(p_base), .o_base(o_base),
    .busy(busy), .done(done),
    .rda_en(rda_en), .rda_addr(rda_addr), .rda_data(rda_data),
    .rdb_en(rdb_en), .rdb_addr(rdb_addr), .rdb_data(rdb_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
    .row_in_en(row_in_en), .row_ps_en(row_ps_en),
    .array_in(array_in), .array_in_partials(array_in_partials),
    .fifo_has_space(fifo_has_space), .out_en(out_en), .row_out(row_out),
    .array_output(array_output), .drained(drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratchpad contents: distinct per address so every row is identifiable.
  function automatic logic [63:0] row_a(input logic [15:0] a);
    return {a, a + 16'h0100, a + 16'h0200, a + 16'h0300};
  endfunction

  function automatic logic [63:0] row_b(input logic [15:0] a);
    return ~row_a(a);
  endfunction

  // Scratchpad read ports: data appears the cycle after the strobe and holds.
  initial begin
    rda_data = '0;
    rdb_data = '0;
  end
  always @(posedge clk) begin
    if (rda_en) rda_data <= row_a(rda_addr);
    if (rdb_en) rdb_data <= row_b(rdb_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [400:0] all_out;
    nRST = 1'b0; start = 1'b0; fifo_has_space = 1'b1; out_en = 1'b1;
    row_out = 2'd1; array_output = 64'h1234; drained = 1'b1;
    w_base = 16'h10; i_base = 16'h20; p_base = 16'h30; o_base = 16'h40;
    #22;
    all_out = {busy, done, rda_en, rda_addr, rdb_en, rdb_addr, wr_en, wr_addr, wr_data,
               weight_en, input_en, partial_en, row_in_en, row_ps_en, array_in, array_in_partials};
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    out_en = 1'b0; drained = 1'b0;
    @(posedge clk); #1;
    nRST = 1'b1;
  endtask

  task automatic test_load();
    logic [7:0]  exp_f;
    logic [15:0] exp_ra, exp_rb;
    logic [63:0] exp_ai, exp_ap;
    logic [1:0]  exp_row;
    bit w, ra, rb, ib;
    fifo_has_space = 1'b1;
    for (int cyc = 0; cyc <= 16; cyc++) begin
      start = (cyc == 0);
      #2;
      w  = (cyc >= 2) && (cyc <= 8) && (cyc % 2 == 0);
      ra = (cyc % 2 == 1) && (cyc <= 15);
      rb = (cyc % 2 == 1) && (cyc >= 9) && (cyc <= 15);
      ib = (cyc % 2 == 0) && (cyc >= 10);
      exp_f = {w, ib, ib, ra, rb, (cyc != 0), 1'b0, 1'b0};
      exp_ra = (cyc <= 7) ? 16'h10 + 16'((cyc - 1) / 2) : 16'h20 + 16'((cyc - 9) / 2);
      exp_rb = 16'h30 + 16'((cyc - 9) / 2);
      exp_row = 2'((cyc - 10) / 2);
      exp_ai = w ? row_a(16'h10 + 16'((cyc - 2) / 2)) : ib ? row_a(16'h20 + 16'(exp_row)) : '0;
      exp_ap = ib ? row_b(16'h30 + 16'(exp_row)) : '0;
      total++;
      if ({weight_en, input_en, partial_en, rda_en, rdb_en, busy, done, wr_en} !== exp_f) begin
        bad++;
        $display("FAIL load_strobes cyc=%0d: got %b want %b", cyc,
                 {weight_en, input_en, partial_en, rda_en, rdb_en, busy, done, wr_en}, exp_f);
      end
      total++;
      if (array_in !== exp_ai || array_in_partials !== exp_ap) begin
        bad++;
        $display("FAIL load_data cyc=%0d: got %h/%h want %h/%h", cyc,
                 array_in, array_in_partials, exp_ai, exp_ap);
      end
      if (ra) begin
        total++;
        if (rda_addr !== exp_ra || (rb && rdb_addr !== exp_rb)) begin
          bad++;
          $display("FAIL load_addr cyc=%0d: got %h/%h want %h/%h", cyc, rda_addr, rdb_addr, exp_ra, exp_rb);
        end
      end
      if (ib) begin
        total++;
        if (row_in_en !== exp_row || row_ps_en !== exp_row) begin
          bad++;
          $display("FAIL load_row cyc=%0d: got %0d/%0d want %0d", cyc, row_in_en, row_ps_en, exp_row);
        end
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_collect();
    logic [15:0] e;
    for (int k = 0; k < 4; k++) begin
      e = 16'h00A0 + 16'(k);
      out_en = 1'b1; row_out = 2'(k); array_output = {4{e}};
      #2;
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 16'h40 + 16'(k) || wr_data !== {4{e}} || done !== 1'b0) begin
        bad++;
        $display("FAIL collect_write row=%0d: got en=%b addr=%h data=%h done=%b want 1 %h %h 0",
                 k, wr_en, wr_addr, wr_data, done, 16'h40 + 16'(k), {4{e}});
      end
      tick();
    end
    out_en = 1'b0; drained = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #2;
      total++;
      if (done !== 1'b0 || busy !== 1'b1 || wr_en !== 1'b0) begin
        bad++;
        $display("FAIL wait_drained c=%0d: got done=%b busy=%b wr_en=%b want 0 1 0", c, done, busy, wr_en);
      end
      tick();
    end
    drained = 1'b1;
    #2;
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: got done=%b busy=%b want 1 0", done, busy);
    end
    tick();
    #2;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL after_done: got done=%b busy=%b want 0 0", done, busy);
    end
    drained = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    int ibc[4] = '{10, 12, 19, 21};
    int rdc[4] = '{9, 11, 13, 20};
    logic [7:0]  exp_f;
    logic [63:0] exp_ai, exp_ap;
    logic [1:0]  row;
    bit w, ra, rb, ib;
    w_base = 16'h10; i_base = 16'h20; p_base = 16'h30; o_base = 16'hFFFE;
    for (int cyc = 0; cyc <= 21; cyc++) begin
      start = (cyc == 0);
      fifo_has_space = !((cyc >= 14) && (cyc <= 18));
      #2;
      w = (cyc >= 2) && (cyc <= 8) && (cyc % 2 == 0);
      ib = 0; rb = 0; row = '0;
      for (int k = 0; k < 4; k++) begin
        if (cyc == ibc[k]) begin ib = 1; row = 2'(k); end
        if (cyc == rdc[k]) begin rb = 1; row = 2'(k); end
      end
      ra = ((cyc % 2 == 1) && (cyc <= 7)) || rb;
      exp_f = {w, ib, ib, ra, rb, (cyc != 0), 1'b0, 1'b0};
      exp_ai = w ? row_a(16'h10 + 16'((cyc - 2) / 2)) : ib ? row_a(16'h20 + 16'(row)) : '0;
      exp_ap = ib ? row_b(16'h30 + 16'(row)) : '0;
      total++;
      if ({weight_en, input_en, partial_en, rda_en, rdb_en, busy, done, wr_en} !== exp_f) begin
        bad++;
        $display("FAIL stall_strobes cyc=%0d: got %b want %b", cyc,
                 {weight_en, input_en, partial_en, rda_en, rdb_en, busy, done, wr_en}, exp_f);
      end
      total++;
      if (array_in !== exp_ai || array_in_partials !== exp_ap) begin
        bad++;
        $display("FAIL stall_data cyc=%0d: got %h/%h want %h/%h", cyc,
                 array_in, array_in_partials, exp_ai, exp_ap);
      end
      if (ib) begin
        total++;
        if (row_in_en !== row || row_ps_en !== row) begin
          bad++;
          $display("FAIL stall_row cyc=%0d: got %0d/%0d want %0d", cyc, row_in_en, row_ps_en, row);
        end
      end
      if (rb) begin
        total++;
        if (rda_addr !== 16'h20 + 16'(row) || rdb_addr !== 16'h30 + 16'(row)) begin
          bad++;
          $display("FAIL stall_addr cyc=%0d: got %h/%h want %h/%h", cyc, rda_addr, rdb_addr,
                   16'h20 + 16'(row), 16'h30 + 16'(row));
        end
      end
      tick();
    end
    start = 1'b0; fifo_has_space = 1'b1;
  endtask

  task automatic test_wrap();
    logic [1:0]  rows[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [15:0] addrs[5] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF};
    logic [15:0] e;
    for (int k = 0; k < 5; k++) begin
      e = 16'h0B00 + 16'(k);
      out_en = 1'b1; row_out = rows[k]; array_output = {4{e}};
      drained = (k == 4);
      #2;
      total++;
      if (wr_en !== 1'b1 || wr_addr !== addrs[k] || wr_data !== {4{e}}) begin
        bad++;
        $display("FAIL wrap_write k=%0d: got en=%b addr=%h data=%h want 1 %h %h",
                 k, wr_en, wr_addr, wr_data, addrs[k], {4{e}});
      end
      total++;
      if (done !== (k == 4)) begin
        bad++;
        $display("FAIL wrap_done k=%0d: got %b want %b", k, done, (k == 4));
      end
      tick();
    end
    out_en = 1'b0; drained = 1'b0;
  endtask

  task automatic test_busy_ignore();
    w_base = 16'h10; i_base = 16'h20; p_base = 16'h30; o_base = 16'h40;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      start = (cyc == 0) || (cyc == 3);
      if (cyc == 3) w_base = 16'h50;
      fifo_has_space = (cyc < 10);
      #2;
      if (cyc == 4) begin
        total++;
        if (weight_en !== 1'b1 || array_in !== row_a(16'h11)) begin
          bad++;
          $display("FAIL busy_start_data: got en=%b data=%h want 1 %h", weight_en, array_in, row_a(16'h11));
        end
      end
      if (cyc == 5) begin
        total++;
        if (rda_en !== 1'b1 || rda_addr !== 16'h12) begin
          bad++;
          $display("FAIL busy_start_addr: got en=%b addr=%h want 1 0012", rda_en, rda_addr);
        end
      end
      if (cyc == 10) begin
        total++;
        if (input_en !== 1'b0 || busy !== 1'b1 || rda_en !== 1'b0) begin
          bad++;
          $display("FAIL busy_stall: got in=%b busy=%b rda=%b want 0 1 0", input_en, busy, rda_en);
        end
      end
      if (cyc < 10) tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [400:0] all_out;
    fifo_has_space = 1'b1; out_en = 1'b1; row_out = 2'd2; array_output = 64'hDEAD; drained = 1'b1;
    nRST = 1'b0;
    #1;
    all_out = {busy, done, rda_en, rda_addr, rdb_en, rdb_addr, wr_en, wr_addr, wr_data,
               weight_en, input_en, partial_en, row_in_en, row_ps_en, array_in, array_in_partials};
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL reset_mid: got %h want 0", all_out);
    end
    tick();
    nRST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      total++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rda_en !== 1'b0) begin
        bad++;
        $display("FAIL idle_out_en c=%0d: got wr=%b busy=%b done=%b rda=%b want 0 0 0 0",
                 c, wr_en, busy, done, rda_en);
      end
      tick();
    end
    out_en = 1'b0; drained = 1'b0;
    w_base = 16'h70; start = 1'b1;
    tick();
    start = 1'b0;
    #2;
    total++;
    if (rda_en !== 1'b1 || rda_addr !== 16'h70 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_after_reset: got en=%b addr=%h busy=%b want 1 0070 1", rda_en, rda_addr, busy);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_collect();
    test_stall();
    test_wrap();
    test_busy_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysarr_mem_driver.md
Name: sysarr_mem_driver

Overview:
- Memory-side initiator for the systolic array load/drain protocol.
- On a start command it reads N weight rows, N input rows and N partial-sum rows from a scratchpad and issues them to the array. It honours fifo_has_space on input/partial beats.
- It captures the N output rows the array returns and writes them back to the scratchpad. It pulses done once the array reports drained.
- Sits between the scratchpad/command logic and the systolic array's memory-facing interface.

Parameters:
N, 4, array dimension (rows/cols); power of two, >=2
DW, 16, element width in bits
AW, 16, scratchpad row-address width

Ports:
clk  in  1  clock
nRST  in  1  asynchronous active-low reset
start  in  1  command strobe; sampled only in IDLE
w_base  in  AW  scratchpad row address of weight row 0
i_base  in  AW  scratchpad row address of input row 0
p_base  in  AW  scratchpad row address of partial row 0
o_base  in  AW  scratchpad row address for output row 0
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job completion
rda_en, rda_addr  out  1, AW  read port A (weights/inputs)
rda_data  in  DW*N  port A data; valid the cycle after rda_en, stable until next rda_en
rdb_en, rdb_addr  out  1, AW  read port B (partials); same timing as A
rdb_data  in  DW*N  port B data
wr_en, wr_addr, wr_data  out  1, AW, DW*N  scratchpad write port
weight_en, input_en, partial_en  out  1 each  array beat strobes
row_in_en, row_ps_en  out  $clog2(N) each  row index for input / partial beat
array_in  out  DW*N  weight or input row (element 0 in MSBs)
array_in_partials  out  DW*N  partial row
fifo_has_space  in  1  array can accept an input/partial beat this cycle
out_en  in  1  array output row valid
row_out  in  $clog2(N)  index of output row
array_output  in  DW*N  output row data
drained  in  1  array has no work in flight

Behaviour:
- Reset: every output 0, state IDLE, all counters 0. Reset mid-job abandons the job with no done pulse.
- States and transitions:
  - IDLE: on start, latch the four bases, clear counters, set busy, go to W_RD.
  - W_RD: rda_en=1, rda_addr=w_base+wr_cnt, go to W_BEAT.
  - W_BEAT: weight_en=1, array_in=rda_data; wr_cnt++. If wr_cnt==N-1, go to I_RD; otherwise go to W_RD. Weight beats are never stalled. Exactly N weight_en cycles, rows 0..N-1 in order.
  - I_RD:
    - Port A: rda_en=1, addr i_base+ir_cnt.
    - Port B: rdb_en=1, addr p_base+ir_cnt.
    - Go to I_BEAT.
  - I_BEAT: when fifo_has_space=1, assert in the same cycle:
    - input_en=1, partial_en=1
    - row_in_en=row_ps_en=ir_cnt
    - array_in=rda_data, array_in_partials=rdb_data
    - ir_cnt++. If ir_cnt==N-1, go to COLLECT; otherwise go to I_RD.
  - I_BEAT stall: if fifo_has_space=0, hold state, strobes low, and do not re-read (relies on the data-stable contract).
  - COLLECT: wait until out_cnt==N and drained=1. Then pulse done, drop busy, go to IDLE.
- Output capture (any non-IDLE state):
  - When out_en=1: wr_en=1, wr_addr=o_base+row_out, wr_data=array_output, combinational same cycle; out_cnt++ (saturates at N).
  - out_en in IDLE is ignored.
  - A duplicate row_out is still written and counted.
- Read/write share no port, so out_en concurrent with any beat needs no arbitration.
- Address arithmetic is modulo 2^AW (wrap-around allowed).
- start while busy is ignored.
- Minimum job latency: 2N (weights) + 2N (inputs) cycles before COLLECT.
- array_in/array_in_partials are 0 when no beat is asserted.

Decomposition:
- sys_arr_pkg gains:
  - the state enum (IDLE, W_RD, W_BEAT, I_RD, I_BEAT, COLLECT)
  - a ROW_W=$clog2(N) constant
- Single module, no sub-module; an interface bundle for the array-facing signals may be reused.

Test Plan:
- N=4, DW=16, w_base=0x10, i_base=0x20, p_base=0x30, o_base=0x40, fifo_has_space=1 -> weight_en high at cycles 2,4,6,8 with rows 0x10..0x13 data; input_en/partial_en beats at rows 0..3, row_in_en=0,1,2,3.
- Same job with fifo_has_space low for 5 cycles during row 2 beat -> beat held, no extra rda_en, array_in stable, row 2 issued once when space returns.
- Model returns out_en rows 0..3 with data 0xA0..0xA3, then drained=1 -> wr_addr 0x40..0x43 with matching data, single done pulse, busy falls the same cycle.
- out_cnt==N but drained=0 for 10 cycles -> no done until drained rises.
- o_base=0xFFFE -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- nRST asserted mid-I_BEAT -> all outputs 0 immediately, IDLE. start while busy is ignored; out_en in IDLE produces no wr_en.
